sd_crc_lane_engine: RTL and testbench

Parametrised bit-serial CRC engine for the SD host controller, the successor to the fixed 7-bit command CRC. Covers CRC7 on the CMD line and CRC16 on 1 or 4 DAT lanes, with one independent CRC per lane. In generate mode it passes payload bits through and then appends the CRC. In check mode it consumes payload plus received CRC and reports per-lane mismatches.

---
 rtl/sd_crc_pkg.sv | 7 +
 rtl/sd_crc_lane_engine_if.sv | 30 +++
 rtl/sd_crc_lane.sv | 33 +++
 rtl/sd_crc_lane_engine.sv | 166 ++++++++++++++++
 tb/tb_sd_crc_lane_engine.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_crc_pkg.sv
// Shared constants and FSM state type for the SD bit-serial CRC engine.
package sd_crc_pkg;
  localparam logic [6:0]  CRC7_POLY  = 7'h09;
  localparam logic [15:0] CRC16_POLY = 16'h1021;

  typedef enum logic [1:0] {IDLE, PAYLOAD, CRC, DONE} state_e;
endpackage

// File: rtl/sd_crc_lane_engine_if.sv
// Frame control, serial bit handshakes and status for sd_crc_lane_engine.
interface sd_crc_lane_engine_if #(
  parameter int LANES = 1,
  parameter int LEN_W = 16
);
  logic             start;
  logic             mode;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [LANES-1:0] in_bits;
  logic             out_valid;
  logic             out_ready;
  logic [LANES-1:0] out_bits;
  logic             out_last;
  logic             busy;
  logic             done;
  logic             crc_ok;
  logic [LANES-1:0] crc_err_mask;

  modport master (
    output start, mode, len, in_valid, in_bits, out_ready,
    input  in_ready, out_valid, out_bits, out_last, busy, done, crc_ok, crc_err_mask
  );

  modport slave (
    input  start, mode, len, in_valid, in_bits, out_ready,
    output in_ready, out_valid, out_bits, out_last, busy, done, crc_ok, crc_err_mask
  );
endinterface

// File: rtl/sd_crc_lane.sv
// One serial CRC register: clear to zero, update with a data bit, or shift the MSB out.
// Latency: register updates on the edge after a control pulse; msb is a direct register tap.
// Backpressure: none here; the caller only pulses update/shift on accepted beats.
module sd_crc_lane
  import sd_crc_pkg::*;
#(
  parameter int               CRC_W = 7,
  parameter logic [CRC_W-1:0] POLY  = CRC7_POLY
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic update,
  input  logic shift,
  input  logic din,
  output logic msb
);
  logic [CRC_W-1:0] crc_q;
  logic             fb;

  assign fb  = din ^ crc_q[CRC_W-1];
  assign msb = crc_q[CRC_W-1];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      crc_q <= '0;
    end else if (update) begin
      crc_q <= {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end else if (shift) begin
      crc_q <= {crc_q[CRC_W-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/sd_crc_lane_engine.sv
// Bit-serial CRC7/CRC16 over LANES lanes: generate (pass-through + append) or check; check mode needs SD_CRC_CHECK_EN.
// Latency: payload passes through combinationally; first CRC beat follows the last payload transfer by one cycle.
// Backpressure: generate mode stalls on in_valid/out_ready; check mode is always ready; stalls freeze counter and CRCs.
module sd_crc_lane_engine
  import sd_crc_pkg::*;
#(
  parameter int               CRC_W = 7,
  parameter logic [CRC_W-1:0] POLY  = CRC7_POLY,
  parameter int               LANES = 1,
  parameter int               LEN_W = 16
) (
  input logic                 clk,
  input logic                 reset,
  sd_crc_lane_engine_if.slave bus
);
  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, cnt_q, cnt_d;
  logic [LANES-1:0] msb;
  logic             chk, beat, crc_last;
  logic             lane_clr, lane_upd, lane_shf;
  logic             in_ready, out_valid, out_last, done;
  logic [LANES-1:0] out_bits;

  assign lane_clr = (state_q == IDLE) && bus.start;
  assign lane_upd = (state_q == PAYLOAD) && beat;
  assign lane_shf = (state_q == CRC) && beat;
  assign crc_last = (cnt_q == LEN_W'(CRC_W - 1));

`ifdef SD_CRC_CHECK_EN
  logic             mode_q, ok_q;
  logic [LANES-1:0] err_q, err_d;

  assign chk = mode_q;

  always_comb begin
    err_d = err_q;
    if (lane_clr) begin
      err_d = '0;
    end else if (lane_shf && chk) begin
      err_d = err_q | (bus.in_bits ^ msb);
    end
  end

  // crc_ok is resolved on the edge into DONE so it lands together with done.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= 1'b0;
      err_q  <= '0;
      ok_q   <= 1'b1;
    end else begin
      err_q <= err_d;
      if (lane_clr) begin
        mode_q <= bus.mode;
        ok_q   <= 1'b1;
      end else if (state_q == CRC && state_d == DONE) begin
        ok_q <= ~|err_d;
      end
    end
  end

  assign bus.crc_err_mask = err_q;
  assign bus.crc_ok       = ok_q;
`else
  assign chk              = 1'b0;
  assign bus.crc_err_mask = '0;
  assign bus.crc_ok       = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    beat      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_bits  = '0;
    out_last  = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cnt_d   = '0;
          state_d = (bus.len == '0) ? CRC : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (chk) begin
          in_ready = 1'b1;
          beat     = bus.in_valid;
        end else begin
          in_ready  = bus.out_ready;
          out_valid = bus.in_valid;
          out_bits  = bus.in_bits;
          beat      = bus.in_valid & bus.out_ready;
        end
        if (beat) begin
          if (cnt_q == len_q - LEN_W'(1)) begin
            cnt_d   = '0;
            state_d = CRC;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      CRC: begin
        if (chk) begin
          in_ready = 1'b1;
          beat     = bus.in_valid;
        end else begin
          out_valid = 1'b1;
          out_bits  = msb;
          out_last  = crc_last;
          beat      = bus.out_ready;
        end
        if (beat) begin
          if (crc_last) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (lane_clr) begin
        len_q <= bus.len;
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sd_crc_lane #(
      .CRC_W (CRC_W),
      .POLY  (POLY)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .clear  (lane_clr),
      .update (lane_upd),
      .shift  (lane_shf),
      .din    (bus.in_bits[l]),
      .msb    (msb[l])
    );
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_bits  = out_bits;
  assign bus.out_last  = out_last;
  assign bus.done      = done;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_sd_crc_lane_engine.sv
// Bench for sd_crc_lane_engine: a CRC7/1-lane and a CRC16/4-lane instance against a polynomial-division model.
module tb_sd_crc_lane_engine;
`ifdef SD_CRC_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        sel, reset_d, start_d, mode_d, in_vld_d, out_rdy_d;
  logic [15:0] len_d;
  logic [3:0]  in_d;
  logic        o_vld, o_last, o_irdy, o_busy, o_done, o_ok;
  logic [3:0]  o_bits, o_mask;

  int n_chk = 0;
  int n_fail = 0;

  logic [3:0]  pay [0:1023];
  logic [15:0] cin [4];
  logic [15:0] obs_crc [4];

  sd_crc_lane_engine_if #(.LANES(1), .LEN_W(16)) if7 ();
  sd_crc_lane_engine_if #(.LANES(4), .LEN_W(16)) if16 ();

  assign if7.start      = start_d & ~sel;
  assign if7.mode       = mode_d;
  assign if7.len        = len_d;
  assign if7.in_valid   = in_vld_d & ~sel;
  assign if7.in_bits    = in_d[0];
  assign if7.out_ready  = out_rdy_d;
  assign if16.start     = start_d & sel;
  assign if16.mode      = mode_d;
  assign if16.len       = len_d;
  assign if16.in_valid  = in_vld_d & sel;
  assign if16.in_bits   = in_d;
  assign if16.out_ready = out_rdy_d;

  always_comb begin
    if (sel) begin
      o_vld = if16.out_valid; o_last = if16.out_last; o_irdy = if16.in_ready;
      o_busy = if16.busy; o_done = if16.done; o_ok = if16.crc_ok;
      o_bits = if16.out_bits; o_mask = if16.crc_err_mask;
    end else begin
      o_vld = if7.out_valid; o_last = if7.out_last; o_irdy = if7.in_ready;
      o_busy = if7.busy; o_done = if7.done; o_ok = if7.crc_ok;
      o_bits = {3'b000, if7.out_bits}; o_mask = {3'b000, if7.crc_err_mask};
    end
  end

  sd_crc_lane_engine #(.CRC_W(7), .POLY(sd_crc_pkg::CRC7_POLY), .LANES(1), .LEN_W(16))
    u_crc7 (.clk(clk), .reset(reset_d), .bus(if7));
  sd_crc_lane_engine #(.CRC_W(16), .POLY(sd_crc_pkg::CRC16_POLY), .LANES(4), .LEN_W(16))
    u_crc16 (.clk(clk), .reset(reset_d), .bus(if16));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Remainder of M(x)*x^cw divided by G(x), computed by textbook long division.
  function automatic logic [15:0] crc_ref(input int cw, input logic [15:0] poly, input int ln, input int lane);
    logic [16:0] rem, gen;
    rem = '0;
    gen = {1'b0, poly} | (17'd1 << cw);
    for (int i = 0; i < ln + cw; i++) begin
      rem = (rem << 1) | {16'd0, (i < ln) ? pay[i][lane] : 1'b0};
      if (rem[cw]) rem = rem ^ gen;
    end
    return rem[15:0];
  endfunction

  task automatic load_cmd(input logic [39:0] c);
    for (int i = 0; i < 40; i++) pay[i] = {3'b000, c[39-i]};
  endtask

  task automatic run_frame(input bit s, input bit md, input int ln, input bit stall,
                           input bit hold, input int rst_at);
    int cw, nl, n_in, pi, cyc, n_last, last_idx, n_done, n_ovld, stab_err, n_bad;
    logic [15:0] poly, v;
    bit em, got_done, rst_done, prev_stall;
    logic [15:0] rf [4];
    logic [3:0] exp_q[$], obs_q[$];
    logic [3:0] prev_bits, emask, lane_m, beat_v;
    cw = s ? 16 : 7;
    nl = s ? 4 : 1;
    poly = s ? 16'h1021 : 16'h0009;
    lane_m = s ? 4'hF : 4'h1;
    em = CHK_EN && md;
    emask = '0;
    for (int l = 0; l < 4; l++) begin
      rf[l] = (l < nl) ? crc_ref(cw, poly, ln, l) : 16'h0;
      if (em && l < nl && cin[l] != rf[l]) emask[l] = 1'b1;
    end
    if (!em) begin
      for (int k = 0; k < ln; k++) exp_q.push_back(pay[k] & lane_m);
      for (int k = 0; k < cw; k++) begin
        beat_v = '0;
        for (int l = 0; l < nl; l++) beat_v[l] = rf[l][cw-1-k];
        exp_q.push_back(beat_v);
      end
    end
    n_in = ln + (em ? cw : 0);
    pi = 0; n_last = 0; last_idx = -1; n_done = 0; n_ovld = 0; stab_err = 0;
    got_done = 0; rst_done = 0; prev_stall = 0; prev_bits = '0;
    sel = s;
    @(negedge clk);
    start_d = 1'b1; mode_d = md; len_d = 16'(ln); in_vld_d = 1'b0; out_rdy_d = 1'b1;
    #1;
    check("idle before start", o_busy, 0);
    cyc = 1;
    for (int t = 0; t < 6000 && !got_done && !rst_done; t++) begin
      @(negedge clk);
      start_d = hold; mode_d = 1'($urandom); len_d = 16'($urandom);
      if (rst_at >= 0 && obs_q.size() == ln + rst_at) begin
        reset_d = 1'b1; in_vld_d = 1'b0; out_rdy_d = 1'b1; start_d = 1'b0;
        @(negedge clk);
        reset_d = 1'b0;
        #1;
        check("reset busy", o_busy, 0);
        check("reset out_valid", o_vld, 0);
        for (int k = 0; k < cw; k++) begin
          if (o_done) n_done++;
          @(negedge clk);
          #1;
        end
        check("no done after reset", n_done, 0);
        rst_done = 1;
      end else begin
        beat_v = '0;
        if (pi < ln) beat_v = pay[pi];
        else if (pi < n_in) for (int l = 0; l < nl; l++) beat_v[l] = cin[l][cw-1-(pi-ln)];
        in_d = beat_v;
        in_vld_d = (pi < n_in) && (!stall || $urandom_range(0, 3) != 0);
        out_rdy_d = !stall || ($urandom_range(0, 2) != 0);
        #1;
        cyc++;
        if (t == 0) check("busy after start", o_busy, 1);
        if (prev_stall && o_vld && o_bits !== prev_bits) stab_err++;
        prev_stall = o_vld && !out_rdy_d;
        prev_bits = o_bits;
        if (o_vld) n_ovld++;
        if (in_vld_d && o_irdy) pi++;
        if (o_vld && out_rdy_d) begin
          if (o_last) begin n_last++; last_idx = obs_q.size(); end
          obs_q.push_back(o_bits);
        end
        if (o_done) begin
          got_done = 1; n_done++;
          check("crc_ok at done", o_ok, emask == 4'h0);
          check("crc_err_mask at done", o_mask, emask);
        end
      end
    end
    if (!rst_done) begin
      check("done seen", got_done, 1);
      @(negedge clk);
      start_d = 1'b0;
      #1;
      check("done one cycle", o_done, 0);
      check("idle after done", o_busy, 0);
      check("crc_err_mask held", o_mask, emask);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        #1;
        if (o_done) n_done++;
      end
      check("done count", n_done, 1);
      check("stream length", obs_q.size(), exp_q.size());
      n_bad = 0;
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++)
        if (obs_q[k] !== exp_q[k]) n_bad++;
      check("stream data", n_bad, 0);
      check("out_last count", n_last, em ? 0 : 1);
      if (!em) check("out_last index", last_idx, ln + cw - 1);
      check("out_valid activity", n_ovld != 0, !em);
      check("stall stability", stab_err, 0);
      if (!stall) check("frame cycles", cyc, ln + cw + 2);
      for (int l = 0; l < 4; l++) begin
        v = '0;
        for (int k = 0; k < cw; k++)
          if (ln + k < obs_q.size()) v = {v[14:0], obs_q[ln+k][l]};
        obs_crc[l] = v;
      end
    end
  endtask

  initial begin
    int ln, s;
    logic [15:0] r;
    sel = 0; reset_d = 1; start_d = 0; mode_d = 0; len_d = '0;
    in_vld_d = 0; out_rdy_d = 0; in_d = '0;
    for (int l = 0; l < 4; l++) begin cin[l] = '0; obs_crc[l] = '0; end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      sel = k[0];
      #1;
      check("reset busy", o_busy, 0);
      check("reset done", o_done, 0);
      check("reset out_valid", o_vld, 0);
      check("reset out_last", o_last, 0);
      check("reset in_ready", o_irdy, 0);
      check("reset out_bits", o_bits, 0);
      check("reset crc_err_mask", o_mask, 0);
      check("reset crc_ok", o_ok, 1);
    end
    @(negedge clk);
    reset_d = 0;

    load_cmd(40'h40_0000_0000);
    run_frame(0, 0, 40, 0, 0, -1);
    check("CMD0 crc7", obs_crc[0], 16'h004A);
    load_cmd(40'h51_0000_0000);
    run_frame(0, 0, 40, 0, 0, -1);
    check("CMD17 crc7", obs_crc[0], 16'h002A);

    load_cmd(40'h11_0000_0900);
    cin[0] = 16'h0033;
    run_frame(0, 1, 40, 0, 0, -1);
    cin[0] = 16'h0033 ^ 16'h0004;
    run_frame(0, 1, 40, 0, 0, -1);

    for (int i = 0; i < 1024; i++) pay[i] = 4'hF;
    run_frame(1, 0, 1024, 0, 0, -1);
    for (int l = 0; l < 4; l++) cin[l] = crc_ref(16, 16'h1021, 1024, l);
    cin[3] = cin[3] ^ 16'h0100;
    run_frame(1, 1, 1024, 0, 0, -1);

    load_cmd(40'h40_0000_0000);
    run_frame(0, 0, 40, 1, 0, -1);
    check("CMD0 crc7 with stalls", obs_crc[0], 16'h004A);
    for (int i = 0; i < 37; i++) pay[i] = 4'($urandom);
    run_frame(1, 0, 37, 1, 0, -1);

    run_frame(0, 0, 0, 0, 0, -1);
    check("len0 crc7", obs_crc[0], 16'h0000);
    run_frame(1, 0, 0, 1, 0, -1);
    check("len0 crc16 lane2", obs_crc[2], 16'h0000);

    load_cmd(40'h40_0000_0000);
    run_frame(0, 0, 40, 0, 0, 4);
    run_frame(0, 0, 40, 0, 0, -1);
    check("CMD0 after reset", obs_crc[0], 16'h004A);

    for (int i = 0; i < 20; i++) pay[i] = 4'($urandom);
    run_frame(0, 0, 20, 0, 1, -1);

    for (int f = 0; f < 12; f++) begin
      s = $urandom_range(0, 1);
      ln = $urandom_range(0, 80);
      for (int i = 0; i < ln; i++) pay[i] = 4'($urandom);
      for (int l = 0; l < 4; l++) begin
        r = (s != 0) ? crc_ref(16, 16'h1021, ln, l) : crc_ref(7, 16'h0009, ln, l);
        if ($urandom_range(0, 2) == 0)
          r = r ^ (16'd1 << ((s != 0) ? $urandom_range(0, 15) : $urandom_range(0, 6)));
        cin[l] = r;
      end
      run_frame(s[0], 1'($urandom), ln, 1'($urandom), 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
